mc8051_tmr: RTL and testbench



---
 rtl/mc8051_tmr_pkg.sv | 27 ++
 rtl/mc8051_tmr_if.sv | 23 ++
 rtl/mc8051_tmr_ch.sv | 130 +++++++++++++
 rtl/mc8051_tmr.sv | 69 ++++++
 tb/tb_mc8051_tmr.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc8051_tmr_pkg.sv
// Shared constants for the mc8051 timer/counter: register offsets inside a
// channel window, CTRL bit positions and the MODE field encodings.
package mc8051_tmr_pkg;

    // Byte offsets inside a 16-byte channel window.
    localparam logic [3:0] OFS_CTRL = 4'd0;
    localparam logic [3:0] OFS_STAT = 4'd1;
    localparam logic [3:0] OFS_CNT0 = 4'd2;
    localparam logic [3:0] OFS_RLD0 = 4'd6;

    // CTRL register layout.
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_CT      = 1;
    localparam int CTRL_GATE    = 2;
    localparam int CTRL_MODE_LO = 3;
    localparam int CTRL_MODE_HI = 4;
    localparam int CTRL_IE      = 5;
    localparam int CTRL_W       = 6;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

endpackage

// File: rtl/mc8051_tmr_if.sv
// SFR bus as seen by the timer block.
// Protocol: sfr_wr and sfr_rd are single-cycle strobes qualified by sfr_addr;
// the block is always ready, so a write lands on the clock edge of its strobe
// cycle. For a read issued in cycle N, sfr_hit is the valid flag in cycle N+1
// and sfr_rdata carries the byte (0 whenever sfr_hit is low).
interface mc8051_tmr_if;
    logic [7:0] sfr_addr;
    logic       sfr_wr;
    logic [7:0] sfr_wdata;
    logic       sfr_rd;
    logic [7:0] sfr_rdata;
    logic       sfr_hit;

    modport master (
        output sfr_addr, sfr_wr, sfr_wdata, sfr_rd,
        input  sfr_rdata, sfr_hit
    );

    modport slave (
        input  sfr_addr, sfr_wr, sfr_wdata, sfr_rd,
        output sfr_rdata, sfr_hit
    );
endinterface

// File: rtl/mc8051_tmr_ch.sv
// One timer/counter channel: pin synchronisers, falling-edge detect, counter
// with free-run/reload/one-shot behaviour, overflow flag, irq register and
// the shadow used for coherent multi-byte counter reads.
module mc8051_tmr_ch
    import mc8051_tmr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       t_pin,
    input  logic       gate_pin,
    input  logic       irq_ack,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [3:0] ofs,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    localparam int NB = CNT_W / 8;

    logic [CTRL_W-1:0] ctrl, ctrl_nxt;
    logic              ovf, ovf_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  reload, reload_nxt;
    logic [CNT_W-1:0]  shadow;
    logic [CNT_W-1:0]  rd_view;
    logic              t_s1, t_s2, t_prev, g_s1, g_s2;
    logic              t_fall, cnt_ev, cnt_wr, all_ones, ovf_ev, ovf_clr;
    mode_e             mode;

    // Two-flop synchronisers plus edge history; reset high so no false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_s1   <= 1'b1;
            t_s2   <= 1'b1;
            t_prev <= 1'b1;
            g_s1   <= 1'b1;
            g_s2   <= 1'b1;
        end else begin
            t_s1   <= t_pin;
            t_s2   <= t_s1;
            t_prev <= t_s2;
            g_s1   <= gate_pin;
            g_s2   <= g_s1;
        end
    end

    assign t_fall   = t_prev & ~t_s2;
    assign mode     = mode_e'(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]);
    assign cnt_ev   = ctrl[CTRL_RUN] & (~ctrl[CTRL_GATE] | g_s2) &
                      (ctrl[CTRL_CT] ? t_fall : tick) & (mode != MODE_HOLD);
    assign all_ones = &cnt;
    assign ovf_ev   = cnt_ev & all_ones;
    assign ovf_clr  = (wr_en & (ofs == OFS_STAT) & wdata[0]) | irq_ack;

    // A CPU write to any implemented counter byte pre-empts counting this cycle.
    always_comb begin
        cnt_wr = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (wr_en && ofs == 4'(OFS_CNT0 + k)) cnt_wr = 1'b1;
        end
    end

    // Next-state for CTRL, OVF, counter and reload.
    always_comb begin
        ctrl_nxt   = ctrl;
        ovf_nxt    = ovf;
        cnt_nxt    = cnt;
        reload_nxt = reload;
        if (cnt_ev && !cnt_wr) begin
            if (all_ones) begin
                case (mode)
                    MODE_RELOAD:  cnt_nxt = reload;
                    MODE_ONESHOT: begin
                        cnt_nxt            = '0;
                        ctrl_nxt[CTRL_RUN] = 1'b0;
                    end
                    default:      cnt_nxt = '0;
                endcase
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
        for (int k = 0; k < NB; k++) begin
            if (wr_en && ofs == 4'(OFS_CNT0 + k)) cnt_nxt[8*k +: 8] = wdata;
            if (wr_en && ofs == 4'(OFS_RLD0 + k)) reload_nxt[8*k +: 8] = wdata;
        end
        if (wr_en && ofs == OFS_CTRL) ctrl_nxt = wdata[CTRL_W-1:0];
        // A set in the same cycle as a clear leaves the flag set.
        if (ovf_ev && !cnt_wr) ovf_nxt = 1'b1;
        else if (ovf_clr)      ovf_nxt = 1'b0;
    end

    // Channel state registers, read shadow and registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl   <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
            reload <= '0;
            shadow <= '0;
            irq    <= 1'b0;
        end else begin
            ctrl   <= ctrl_nxt;
            ovf    <= ovf_nxt;
            cnt    <= cnt_nxt;
            reload <= reload_nxt;
            if (rd_en && ofs == OFS_CNT0) shadow <= cnt;
            irq    <= ovf & ctrl[CTRL_IE];
        end
    end

    // Read data: counter byte 0 is live, upper bytes come from the shadow.
    always_comb begin
        rdata         = '0;
        rd_view       = shadow;
        rd_view[7:0]  = cnt[7:0];
        if (ofs == OFS_CTRL) rdata = {{(8 - CTRL_W){1'b0}}, ctrl};
        if (ofs == OFS_STAT) rdata = {7'b0, ovf};
        for (int k = 0; k < NB; k++) begin
            if (ofs == 4'(OFS_CNT0 + k)) rdata = rd_view[8*k +: 8];
            if (ofs == 4'(OFS_RLD0 + k)) rdata = reload[8*k +: 8];
        end
    end

endmodule

// File: rtl/mc8051_tmr.sv
// Multi-channel 8051-style timer/counter on the SFR bus. Decodes the 16-byte
// channel windows starting at BASE_ADDR and registers the read mux.
module mc8051_tmr
    import mc8051_tmr_pkg::*;
#(
    parameter int         NUM_CH    = 2,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] BASE_ADDR = 8'h80
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    mc8051_tmr_if.slave       bus,
    input  logic [NUM_CH-1:0] t_pin,
    input  logic [NUM_CH-1:0] gate_pin,
    input  logic [NUM_CH-1:0] irq_ack,
    output logic [NUM_CH-1:0] irq
);

    logic [8:0] diff;
    logic [3:0] ch_sel;
    logic [3:0] ofs;
    logic       in_win;
    logic [7:0] sel_data;
    logic [7:0] ch_rdata [NUM_CH];

    // Nine-bit subtraction so addresses below BASE_ADDR borrow into bit 8.
    assign diff   = {1'b0, bus.sfr_addr} - {1'b0, BASE_ADDR};
    assign ch_sel = diff[7:4];
    assign ofs    = diff[3:0];
    assign in_win = ~diff[8] & ({1'b0, ch_sel} < 5'(NUM_CH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mc8051_tmr_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .t_pin    (t_pin[c]),
            .gate_pin (gate_pin[c]),
            .irq_ack  (irq_ack[c]),
            .wr_en    (bus.sfr_wr & in_win & (ch_sel == 4'(c))),
            .rd_en    (bus.sfr_rd & in_win & (ch_sel == 4'(c))),
            .ofs      (ofs),
            .wdata    (bus.sfr_wdata),
            .rdata    (ch_rdata[c]),
            .irq      (irq[c])
        );
    end

    // Select the addressed channel's read byte.
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c)) sel_data = ch_rdata[c];
        end
    end

    // Registered read response; data is forced to 0 when the read misses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sfr_rdata <= '0;
            bus.sfr_hit   <= 1'b0;
        end else begin
            bus.sfr_rdata <= (bus.sfr_rd && in_win) ? sel_data : 8'h00;
            bus.sfr_hit   <= bus.sfr_rd & in_win;
        end
    end

endmodule

// File: tb/tb_mc8051_tmr.sv
// Directed bench for mc8051_tmr (2 channels, 16-bit). Reads push their
// expected byte into a queue; a negedge monitor pops and compares whenever
// the DUT raises sfr_hit.
module tb_mc8051_tmr;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] t_pin = 2'b11;
    logic [1:0] gate_pin = 2'b11;
    logic [1:0] irq_ack = 2'b00;
    logic [1:0] irq;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] mon_exp;
    logic [7:0] mon_addr;

    mc8051_tmr_if sfr_bus();

    mc8051_tmr #(.NUM_CH(2), .CNT_W(16), .BASE_ADDR(8'h80)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .bus      (sfr_bus),
        .t_pin    (t_pin),
        .gate_pin (gate_pin),
        .irq_ack  (irq_ack),
        .irq      (irq)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read response is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (sfr_bus.sfr_hit === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_unexpected: got hit with data 0x%0h, want no hit", sfr_bus.sfr_rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_addr = addr_q.pop_front();
                chk($sformatf("rd_%02h", mon_addr), 32'(sfr_bus.sfr_rdata), 32'(mon_exp));
            end
        end
    end

    // Driver tasks: strobes set before cyc() last exactly one clock.
    task automatic cyc();
        @(negedge clk);
        tick           = 1'b0;
        sfr_bus.sfr_rd = 1'b0;
        sfr_bus.sfr_wr = 1'b0;
        irq_ack        = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        sfr_bus.sfr_addr  = a;
        sfr_bus.sfr_wdata = d;
        sfr_bus.sfr_wr    = 1'b1;
        cyc();
    endtask

    task automatic rd_issue(input logic [7:0] a, input logic [7:0] e);
        sfr_bus.sfr_addr = a;
        sfr_bus.sfr_rd   = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        rd_issue(a, e);
        cyc();
    endtask

    task automatic miss(input logic [7:0] a);
        sfr_bus.sfr_addr = a;
        sfr_bus.sfr_rd   = 1'b1;
        cyc();
        chk("miss_hit", 32'(sfr_bus.sfr_hit), 32'd0);
        chk("miss_data", 32'(sfr_bus.sfr_rdata), 32'd0);
    endtask

    task automatic wr_cnt(input logic [7:0] base, input logic [15:0] v);
        wr(base + 8'd2, v[7:0]);
        wr(base + 8'd3, v[15:8]);
    endtask

    task automatic rd_cnt(input logic [7:0] base, input logic [15:0] v);
        rd(base + 8'd2, v[7:0]);
        rd(base + 8'd3, v[15:8]);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sfr_bus.sfr_addr  = 8'h00;
        sfr_bus.sfr_wdata = 8'h00;
        sfr_bus.sfr_wr    = 1'b0;
        sfr_bus.sfr_rd    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_hit", 32'(sfr_bus.sfr_hit), 32'd0);
        chk("rst_rdata", 32'(sfr_bus.sfr_rdata), 32'd0);
        reset_n = 1'b1;
        cyc();
        rd(8'h80, 8'h00);
        rd_cnt(8'h80, 16'h0000);
        rd(8'h86, 8'h00);
        rd(8'h91, 8'h00);
        miss(8'h7F);
        miss(8'hA0);

        // Free-run overflow with IE, then irq_ack
        wr_cnt(8'h80, 16'hFFFE);
        wr(8'h80, 8'h21);
        repeat (2) begin
            idle(11);
            tick = 1'b1;
            cyc();
        end
        chk("t1_irq_lag", 32'(irq), 32'd0);
        cyc();
        chk("t1_irq", 32'(irq), 32'd1);
        rd_cnt(8'h80, 16'h0000);
        rd(8'h81, 8'h01);
        irq_ack[0] = 1'b1;
        cyc();
        rd(8'h81, 8'h00);
        chk("t1_ack_irq", 32'(irq), 32'd0);
        wr(8'h80, 8'h00);

        // Auto-reload on channel 1, IE clear
        wr(8'h96, 8'h00);
        wr(8'h97, 8'hFF);
        wr_cnt(8'h90, 16'hFFFF);
        wr(8'h90, 8'h09);
        tick = 1'b1;
        cyc();
        cyc();
        rd_cnt(8'h90, 16'hFF00);
        rd(8'h91, 8'h01);
        rd(8'h90, 8'h09);
        rd(8'h97, 8'hFF);
        chk("t2_irq_ie0", 32'(irq), 32'd0);
        wr(8'h91, 8'h01);
        rd(8'h91, 8'h00);
        wr(8'h90, 8'h00);

        // One-shot counter on t_pin falling edge, 3-clock latency
        wr_cnt(8'h80, 16'hFFFF);
        wr(8'h80, 8'h13);
        t_pin[0] = 1'b0;
        cyc();
        cyc();
        rd(8'h80, 8'h13);
        rd(8'h80, 8'h12);
        rd_cnt(8'h80, 16'h0000);
        rd(8'h81, 8'h01);
        repeat (2) begin
            t_pin[0] = 1'b1;
            idle(4);
            t_pin[0] = 1'b0;
            idle(4);
        end
        rd_cnt(8'h80, 16'h0000);
        wr(8'h81, 8'h01);
        rd(8'h81, 8'h00);

        // Gating on channel 1
        wr_cnt(8'h90, 16'h0000);
        gate_pin[1] = 1'b0;
        idle(3);
        wr(8'h90, 8'h05);
        for (int i = 0; i < 24; i++) begin
            if (i % 12 == 11) tick = 1'b1;
            cyc();
        end
        rd_cnt(8'h90, 16'h0000);
        gate_pin[1] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i % 12 == 11) tick = 1'b1;
            cyc();
        end
        rd_cnt(8'h90, 16'h0002);
        wr(8'h90, 8'h00);

        // Coherent read across a carry, plus unimplemented offsets
        wr(8'h80, 8'h00);
        wr_cnt(8'h80, 16'h12FF);
        wr(8'h80, 8'h01);
        tick = 1'b1;
        rd_issue(8'h82, 8'hFF);
        cyc();
        rd(8'h83, 8'h12);
        wr(8'h80, 8'h00);
        rd(8'h82, 8'h00);
        rd(8'h83, 8'h13);
        rd(8'h84, 8'h00);
        wr(8'h84, 8'hAA);
        rd(8'h84, 8'h00);
        wr(8'h8A, 8'h5A);
        rd(8'h8A, 8'h00);
        rd(8'h8F, 8'h00);

        // OVF set beats STAT clear in the same cycle
        wr_cnt(8'h80, 16'hFFFF);
        wr(8'h80, 8'h01);
        tick              = 1'b1;
        sfr_bus.sfr_addr  = 8'h81;
        sfr_bus.sfr_wdata = 8'h01;
        sfr_bus.sfr_wr    = 1'b1;
        cyc();
        wr(8'h80, 8'h00);
        rd(8'h81, 8'h01);
        rd_cnt(8'h80, 16'h0000);
        wr(8'h81, 8'h01);
        rd(8'h81, 8'h00);

        // CNT byte write beats a tick
        wr_cnt(8'h80, 16'h1234);
        wr(8'h80, 8'h01);
        tick              = 1'b1;
        sfr_bus.sfr_addr  = 8'h82;
        sfr_bus.sfr_wdata = 8'h55;
        sfr_bus.sfr_wr    = 1'b1;
        cyc();
        wr(8'h80, 8'h00);
        rd_cnt(8'h80, 16'h1255);

        // CNT byte write beats a one-shot overflow
        wr_cnt(8'h80, 16'hFFFF);
        wr(8'h80, 8'h11);
        tick              = 1'b1;
        sfr_bus.sfr_addr  = 8'h83;
        sfr_bus.sfr_wdata = 8'h00;
        sfr_bus.sfr_wr    = 1'b1;
        cyc();
        rd(8'h80, 8'h11);
        rd_cnt(8'h80, 16'h00FF);
        rd(8'h81, 8'h00);
        wr(8'h80, 8'h00);

        // Asynchronous reset with irq high and a read response in flight
        wr_cnt(8'h80, 16'hFFFF);
        wr(8'h80, 8'h21);
        tick = 1'b1;
        cyc();
        cyc();
        chk("rst_pre_irq", 32'(irq), 32'd1);
        sfr_bus.sfr_addr = 8'h80;
        sfr_bus.sfr_rd   = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_pre_data", 32'(sfr_bus.sfr_rdata), 32'h21);
        reset_n = 1'b0;
        #1;
        chk("rst_async_irq", 32'(irq), 32'd0);
        chk("rst_async_hit", 32'(sfr_bus.sfr_hit), 32'd0);
        chk("rst_async_data", 32'(sfr_bus.sfr_rdata), 32'd0);
        cyc();
        idle(2);
        reset_n = 1'b1;
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b1;
        cyc();
        rd(8'h80, 8'h00);
        rd(8'h81, 8'h00);
        rd_cnt(8'h80, 16'h0000);
        chk("rst_post_irq", 32'(irq), 32'd0);

        // Upper byte before any byte-0 read returns the cleared shadow
        wr_cnt(8'h80, 16'h3400);
        rd(8'h83, 8'h00);
        rd(8'h82, 8'h00);
        rd(8'h83, 8'h34);

        idle(2);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
